// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the fetch/sequencing unit: opcode constants,
// sequencer state encoding and default widths.
package pacote_processador;

  localparam int ADDR_W_PADRAO = 10;
  localparam int DATA_W_PADRAO = 32;

  localparam logic [5:0] OP_FIM           = 6'b011111;
  localparam logic [5:0] OP_ULTIMO_VALIDO = 6'b100110;

  typedef enum logic [1:0] {
    BUSCA  = 2'd0,
    EXEC   = 2'd1,
    ESPERA = 2'd2,
    PARADO = 2'd3
  } estado_t;

  function automatic logic opcode_indefinido(input logic [5:0] op);
    return op > OP_ULTIMO_VALIDO;
  endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// Bundle between the fetch unit, instruction memory, control unit and operator button.
// master = fetch unit side, slave = everything around it.
interface unidade_busca_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] instrucao;
  logic [ADDR_W-1:0] endInstrucao;
  logic [5:0]        opcode;
  logic              DesvioControl;
  logic              jumpControl;
  logic              branchControl;
  logic              branchTipo;
  logic              ulaZero;
  logic              status;
  logic [DATA_W-1:0] regValor;
  logic              confirma;
  logic [ADDR_W-1:0] pcLink;
  logic              commit;
  logic              espera;
  logic              parado;

  modport master (
    input  instrucao, DesvioControl, jumpControl, branchControl, branchTipo,
           ulaZero, status, regValor, confirma,
    output endInstrucao, opcode, pcLink, commit, espera, parado
  );

  modport slave (
    output instrucao, DesvioControl, jumpControl, branchControl, branchTipo,
           ulaZero, status, regValor, confirma,
    input  endInstrucao, opcode, pcLink, commit, espera, parado
  );
endinterface

// File: rtl/unidade_busca_sincroniza_borda.sv
// Two-flop synchronizer for an asynchronous push-button followed by a
// registered rising-edge detector producing a one-cycle pulse.
module sincroniza_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal_i,
  output logic borda_o
);
  // [0],[1] synchronizer stages, [2] previous synchronized value
  logic [2:0] sinc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sinc_q <= '0;
    else        sinc_q <= {sinc_q[1:0], sinal_i};
  end

  assign borda_o = sinc_q[1] & ~sinc_q[2];
endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch/sequencing unit: holds PC and IR, walks BUSCA/EXEC,
// computes the next PC from control-unit feedback, waits for the operator and halts on fim.
module unidade_busca
  import pacote_processador::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO,
  parameter int DATA_W = DATA_W_PADRAO
) (
  input logic             clock,
  input logic             reset,
  unidade_busca_if.master bus
);
  localparam logic [ADDR_W-1:0] UM = 1;

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [5:0]        ir_q;
  logic              espera_q, parado_q;
  logic              borda_confirma;
  logic [5:0]        opcode_atual;
  logic [ADDR_W-1:0] pc_mais_um;
  logic              desvio_tomado;
  logic              commit;

  sincroniza_borda u_sincroniza_borda (
    .clk     (clock),
    .rst_n   (reset),
    .sinal_i (bus.confirma),
    .borda_o (borda_confirma)
  );

  // During EXEC the control unit must see the fresh opcode in the same cycle; IR keeps it afterwards.
  assign opcode_atual  = (estado_q == EXEC) ? bus.instrucao[DATA_W-1 -: 6] : ir_q;
  assign pc_mais_um    = pc_q + UM;
  assign desvio_tomado = bus.branchControl & (bus.ulaZero ^ bus.branchTipo);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    commit   = 1'b0;
    case (estado_q)
      BUSCA: estado_d = EXEC;
      EXEC: begin
        if (opcode_atual == OP_FIM) begin
          estado_d = PARADO;
        end else if (bus.status) begin
          estado_d = ESPERA;
        end else begin
          estado_d = BUSCA;
          if (bus.DesvioControl) begin
            pc_d   = bus.jumpControl ? bus.regValor[ADDR_W-1:0] : bus.instrucao[ADDR_W-1:0];
            commit = 1'b1;
          end else if (desvio_tomado) begin
            pc_d   = bus.instrucao[ADDR_W-1:0];
            commit = 1'b1;
          end else begin
            pc_d   = pc_mais_um;
            commit = ~opcode_indefinido(opcode_atual);
          end
        end
      end
      ESPERA: begin
        if (borda_confirma) begin
          pc_d     = pc_mais_um;
          commit   = 1'b1;
          estado_d = BUSCA;
        end
      end
      PARADO:  estado_d = PARADO;
      default: estado_d = BUSCA;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= BUSCA;
      pc_q     <= '0;
      ir_q     <= '0;
      espera_q <= 1'b0;
      parado_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      if (estado_q == EXEC) ir_q <= opcode_atual;
      espera_q <= (estado_d == ESPERA);
      parado_q <= (estado_d == PARADO);
    end
  end

  assign bus.endInstrucao = pc_q;
  assign bus.opcode       = opcode_atual;
  assign bus.pcLink       = (estado_q == EXEC) ? pc_mais_um : '0;
  assign bus.commit       = commit;
  assign bus.espera       = espera_q;
  assign bus.parado       = parado_q;
endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed vector table, random instructions
// against a behavioural next-PC model, and hand sequences for ESPERA, PARADO and reset.
module tb_unidade_busca;
  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  unidade_busca_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  unidade_busca dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  pc;
    logic [5:0]  op;
    logic [25:0] imm;
    logic        des, jr, br, tipo, zero;
    logic [31:0] regv;
    logic        cm;
    logic [9:0]  nxt;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [9:0] pc, input logic [5:0] op, input logic [25:0] imm,
                         input logic des, input logic jr, input logic br, input logic tipo,
                         input logic zero, input logic [31:0] regv, input logic cm,
                         input logic [9:0] nxt);
    vec_t v;
    v.pc = pc; v.op = op; v.imm = imm; v.des = des; v.jr = jr; v.br = br;
    v.tipo = tipo; v.zero = zero; v.regv = regv; v.cm = cm; v.nxt = nxt;
    tab.push_back(v);
  endtask

  // Behavioural next-PC rule for a non-fim, non-status instruction.
  function automatic void modelo(input int pc, input logic [5:0] op, input logic [25:0] imm,
                                 input logic des, input logic jr, input logic br,
                                 input logic tipo, input logic zero, input logic [31:0] regv,
                                 output int nxt, output logic cm);
    bit tomado;
    tomado = br && (tipo ? !zero : zero);
    if (des) begin
      nxt = jr ? int'(regv % 32'd1024) : int'(imm % 26'd1024);
      cm  = 1'b1;
    end else if (tomado) begin
      nxt = int'(imm % 26'd1024);
      cm  = 1'b1;
    end else begin
      nxt = (pc + 1) % 1024;
      cm  = (int'(op) <= 38);
    end
  endfunction

  // Entered at posedge+1 of a BUSCA cycle; leaves at posedge+1 of the following state.
  task automatic do_instr(input logic [9:0] pc, input logic [5:0] op, input logic [25:0] imm,
                          input logic des, input logic jr, input logic br, input logic tipo,
                          input logic zero, input logic stat, input logic [31:0] regv,
                          input logic cm, input logic [9:0] nxt);
    logic [9:0] link;
    link = pc + 10'd1;
    bus.instrucao     = {op, imm};
    bus.DesvioControl = des;
    bus.jumpControl   = jr;
    bus.branchControl = br;
    bus.branchTipo    = tipo;
    bus.ulaZero       = zero;
    bus.status        = stat;
    bus.regValor      = regv;
    #1;
    check("busca_end", bus.endInstrucao, pc);
    check("busca_commit", bus.commit, 0);
    check("busca_flags", {bus.espera, bus.parado}, 0);
    @(posedge clock); #1;
    check("exec_end", bus.endInstrucao, pc);
    check("exec_opcode", bus.opcode, op);
    check("exec_pclink", bus.pcLink, link);
    check("exec_commit", bus.commit, cm);
    @(posedge clock); #1;
    check("next_end", bus.endInstrucao, nxt);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_end"}, bus.endInstrucao, 0);
    check({name, "_opcode"}, bus.opcode, 0);
    check({name, "_pclink"}, bus.pcLink, 0);
    check({name, "_flags"}, {bus.commit, bus.espera, bus.parado}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          model_pc;
    int          nxt_i;
    logic        cm_r;
    logic [5:0]  op_r;
    logic [25:0] imm_r;
    logic [31:0] regv_r;
    logic        des_r, jr_r, br_r, tipo_r, zero_r;
    bit          found;
    int          lat;

    n_vec = 0;
    n_err = 0;
    bus.instrucao = '0; bus.DesvioControl = 0; bus.jumpControl = 0; bus.branchControl = 0;
    bus.branchTipo = 0; bus.ulaZero = 0; bus.status = 0; bus.regValor = '0; bus.confirma = 0;

    reset = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    //       pc      op     imm          des jr br tp z  regv          cm nxt
    add_vec(10'h000, 6'h00, 26'h0,       0, 0, 0, 0, 0, 32'h0,        1, 10'h001);
    add_vec(10'h001, 6'h08, 26'h5,       0, 0, 0, 0, 0, 32'h0,        1, 10'h002);
    add_vec(10'h002, 6'h02, 26'h5,       1, 0, 0, 0, 0, 32'h0,        1, 10'h005);
    add_vec(10'h005, 6'h02, 26'h3F0,     1, 0, 0, 0, 0, 32'h0,        1, 10'h3F0);
    add_vec(10'h3F0, 6'h03, 26'h0,       1, 1, 0, 0, 0, 32'h12,       1, 10'h012);
    add_vec(10'h012, 6'h02, 26'h7,       1, 0, 0, 0, 0, 32'h0,        1, 10'h007);
    add_vec(10'h007, 6'h04, 26'h100,     1, 0, 0, 0, 0, 32'h0,        1, 10'h100);
    add_vec(10'h100, 6'h05, 26'h200,     0, 0, 1, 0, 1, 32'h0,        1, 10'h200);
    add_vec(10'h200, 6'h05, 26'h300,     0, 0, 1, 0, 0, 32'h0,        1, 10'h201);
    add_vec(10'h201, 6'h06, 26'h050,     0, 0, 1, 1, 0, 32'h0,        1, 10'h050);
    add_vec(10'h050, 6'h06, 26'h123,     0, 0, 1, 1, 1, 32'h0,        1, 10'h051);
    add_vec(10'h051, 6'h02, 26'h3FF,     1, 0, 0, 0, 0, 32'h0,        1, 10'h3FF);
    add_vec(10'h3FF, 6'h00, 26'h0,       0, 0, 0, 0, 0, 32'h0,        1, 10'h000);
    add_vec(10'h000, 6'h3F, 26'h0,       0, 0, 0, 0, 0, 32'h0,        0, 10'h001);
    add_vec(10'h001, 6'h02, 26'h2ABCD,   1, 0, 0, 0, 0, 32'h0,        1, 10'h3CD);
    add_vec(10'h3CD, 6'h03, 26'h0,       1, 1, 0, 0, 0, 32'hFFFFF805, 1, 10'h005);
    add_vec(10'h005, 6'h27, 26'h3,       1, 0, 0, 0, 0, 32'h0,        1, 10'h003);
    add_vec(10'h003, 6'h27, 26'h0,       0, 0, 0, 0, 0, 32'h0,        0, 10'h004);
    add_vec(10'h004, 6'h26, 26'h0,       0, 0, 0, 0, 0, 32'h0,        1, 10'h005);
    add_vec(10'h005, 6'h27, 26'h010,     0, 0, 1, 0, 1, 32'h0,        1, 10'h010);

    for (int i = 0; i < tab.size(); i++)
      do_instr(tab[i].pc, tab[i].op, tab[i].imm, tab[i].des, tab[i].jr, tab[i].br,
               tab[i].tipo, tab[i].zero, 1'b0, tab[i].regv, tab[i].cm, tab[i].nxt);

    model_pc = 'h010;
    for (int i = 0; i < 120; i++) begin
      op_r = 6'($urandom_range(0, 63));
      if (op_r == 6'h1F) op_r = 6'h00;
      imm_r  = 26'($urandom);
      regv_r = $urandom;
      des_r  = ($urandom_range(0, 3) == 0);
      jr_r   = 1'($urandom);
      br_r   = ($urandom_range(0, 2) == 0);
      tipo_r = 1'($urandom);
      zero_r = 1'($urandom);
      modelo(model_pc, op_r, imm_r, des_r, jr_r, br_r, tipo_r, zero_r, regv_r, nxt_i, cm_r);
      do_instr(10'(model_pc), op_r, imm_r, des_r, jr_r, br_r, tipo_r, zero_r, 1'b0, regv_r,
               cm_r, 10'(nxt_i));
      model_pc = nxt_i;
    end

    // Operator wait: confirma already high on entry must be ignored.
    bus.confirma = 1'b1;
    do_instr(10'(model_pc), 6'h02, 26'h3, 1, 0, 0, 0, 0, 1'b0, 32'h0, 1'b1, 10'h003);
    do_instr(10'h003, 6'h1A, 26'h0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 1'b0, 10'h003);
    bus.status = 1'b0;
    check("espera_entry", bus.espera, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      check("espera_held_high", {bus.espera, bus.commit}, 2'b10);
      check("espera_opcode", bus.opcode, 6'h1A);
      check("espera_end", bus.endInstrucao, 3);
    end
    bus.confirma = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("espera_released", {bus.espera, bus.commit}, 2'b10);
    end
    bus.confirma = 1'b1;
    found = 0;
    lat   = 0;
    for (int i = 1; i <= 6 && !found; i++) begin
      @(posedge clock); #1;
      if (bus.commit) begin
        found = 1;
        lat   = i;
      end
    end
    check("confirma_within_3", (found && lat <= 3), 1);
    check("confirma_commit_in_espera", bus.espera, 1);
    @(posedge clock); #1;
    check("after_espera_end", bus.endInstrucao, 4);
    check("after_espera_flags", {bus.commit, bus.espera}, 0);
    bus.confirma = 1'b0;

    // Halt: fim wins over DesvioControl and stays put until reset.
    do_instr(10'h004, 6'h02, 26'h9, 1, 0, 0, 0, 0, 1'b0, 32'h0, 1'b1, 10'h009);
    do_instr(10'h009, 6'h1F, 26'h2AA, 1, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 10'h009);
    for (int i = 0; i < 100; i++) begin
      check("parado_hold", {bus.parado, bus.commit, bus.endInstrucao}, {2'b10, 10'h009});
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    check_all_zero("reset_parado");
    @(posedge clock); #1;
    reset = 1'b1;
    do_instr(10'h000, 6'h00, 26'h0, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b1, 10'h001);

    // Reset in the middle of ESPERA.
    do_instr(10'h001, 6'h1A, 26'h0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 1'b0, 10'h001);
    bus.status = 1'b0;
    @(posedge clock); #2;
    check("mid_espera_before", bus.espera, 1);
    reset = 1'b0;
    #1;
    check_all_zero("reset_espera");
    @(posedge clock); #1;
    reset = 1'b1;
    do_instr(10'h000, 6'h08, 26'h0, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b1, 10'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
